// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder: debounces an active-low 7-seg bus, decodes stable glyphs to hex, offers them on valid/ready
module seg7_capture_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH         = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [6:0]         seg_in,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [3:0]         out_digit,
  output logic               err_pulse,
  output logic [7:0]         err_count,
  output logic [7:0]         digit_count,
  output logic [4*DEPTH-1:0] history
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic [1:0] {WAIT, SETTLE, EMIT, HOLD} state_t;
  state_t        r_state, w_state;
  logic [6:0]    r_seg_q, r_cand, w_cand;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [3:0]    w_dec;
  logic          w_legal, w_blank, w_same, w_done, w_emit, w_err, w_accept;
  assign w_blank = r_seg_q == 7'h7F;
  assign w_same  = r_seg_q == r_cand;
  assign w_done  = r_cnt == CW'(STABLE_CYCLES - 1);
  always_comb begin
    w_legal = 1'b1;
    w_dec   = 4'h0;
    case (r_cand)
      7'h40: w_dec = 4'h0;
      7'h79: w_dec = 4'h1;
      7'h24: w_dec = 4'h2;
      7'h30: w_dec = 4'h3;
      7'h19: w_dec = 4'h4;
      7'h12: w_dec = 4'h5;
      7'h02: w_dec = 4'h6;
      7'h78: w_dec = 4'h7;
      7'h00: w_dec = 4'h8;
      7'h10: w_dec = 4'h9;
      7'h08: w_dec = 4'hA;
      7'h03: w_dec = 4'hB;
      7'h46: w_dec = 4'hC;
      7'h21: w_dec = 4'hD;
      7'h06: w_dec = 4'hE;
      7'h0E: w_dec = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end
  always_comb begin
    w_state  = r_state;
    w_cand   = r_cand;
    w_cnt    = r_cnt;
    w_emit   = 1'b0;
    w_err    = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      WAIT: if (!w_blank) begin
        w_cand  = r_seg_q;
        w_cnt   = CW'(1);
        w_state = SETTLE;
      end
      SETTLE: if (w_blank) w_state = WAIT;
      else if (!w_same) begin
        w_cand = r_seg_q;
        w_cnt  = CW'(1);
      end
      else if (!w_done) w_cnt = r_cnt + CW'(1);
      else if (w_legal) begin
        w_emit  = 1'b1;
        w_state = EMIT;
      end
      else begin
        w_err   = 1'b1;
        w_state = HOLD;
      end
      // the bus is deliberately ignored until the consumer takes the digit
      EMIT: if (out_ready) begin
        w_accept = 1'b1;
        w_state  = HOLD;
      end
      HOLD: if (w_blank) w_state = WAIT;
      else if (!w_same) begin
        w_cand  = r_seg_q;
        w_cnt   = CW'(1);
        w_state = SETTLE;
      end
      default: w_state = WAIT;
    endcase
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= WAIT;
      r_seg_q     <= 7'h7F;
      r_cand      <= 7'h7F;
      r_cnt       <= '0;
      out_valid   <= 1'b0;
      out_digit   <= 4'h0;
      err_pulse   <= 1'b0;
      err_count   <= 8'h00;
      digit_count <= 8'h00;
      history     <= '0;
    end else begin
      r_state   <= w_state;
      r_seg_q   <= seg_in;
      r_cand    <= w_cand;
      r_cnt     <= w_cnt;
      err_pulse <= w_err;
      if (w_emit) begin
        out_valid <= 1'b1;
        out_digit <= w_dec;
      end
      if (w_accept) begin
        out_valid   <= 1'b0;
        history     <= {history[4*DEPTH-5:0], out_digit};
        digit_count <= digit_count + {7'd0, digit_count != 8'hFF};
      end
      if (w_err) err_count <= err_count + {7'd0, err_count != 8'hFF};
    end
  end
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// tb_seg7_capture_decoder: directed and random glyph runs scored against a run-level model of the decoder
module tb_seg7_capture_decoder;
  localparam int S = 4;
  localparam int D = 4;
  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic [6:0]   seg_in = 7'h7F;
  logic         out_ready = 1'b0;
  logic         out_valid, err_pulse;
  logic [3:0]   out_digit;
  logic [7:0]   err_count, digit_count;
  logic [4*D-1:0] history;
  int checks = 0, failures = 0;
  int exp_q[$];
  int acc[$];
  int base = 0, exp_err = 0, err_total_exp = 0, err_seen = 0;
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_capture_decoder #(.STABLE_CYCLES(S), .DEPTH(D)) dut (
    .clock(clock), .resetn(resetn), .seg_in(seg_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_digit(out_digit), .err_pulse(err_pulse),
    .err_count(err_count), .digit_count(digit_count), .history(history)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [15:0] exp_hist();
    logic [15:0] h = 16'h0;
    int lo = (acc.size() - base > 4) ? acc.size() - 4 : base;
    for (int i = lo; i < acc.size(); i++) h = {h[11:0], 4'(acc[i])};
    return h;
  endfunction

  always @(negedge clock) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_emit actual=%0h required=none", out_digit);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("emit_digit", {28'd0, out_digit}, e);
        acc.push_back(e);
      end
    end
    if (err_pulse) err_seen++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    step(n);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_digit"}, {28'd0, out_digit}, 0);
    chk({tag, "_errp"}, {31'd0, err_pulse}, 0);
    chk({tag, "_errc"}, {24'd0, err_count}, 0);
    chk({tag, "_dcnt"}, {24'd0, digit_count}, 0);
    chk({tag, "_hist"}, {16'd0, history}, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk_zero("reset");
    exp_q.delete();
    base = acc.size();
    exp_err = 0;
    seg_in = 7'h7F;
    step(2);
    resetn = 1'b1;
    step(1);
  endtask

  task automatic chk_state(input string tag);
    int n = acc.size() - base;
    chk({tag, "_hist"}, {16'd0, history}, {16'd0, exp_hist()});
    chk({tag, "_dcnt"}, {24'd0, digit_count}, n > 255 ? 255 : n);
    chk({tag, "_errc"}, {24'd0, err_count}, exp_err > 255 ? 255 : exp_err);
    chk({tag, "_errp"}, err_seen, err_total_exp);
  endtask

  initial begin
    logic [6:0] p, prev;
    int len, d;
    seg_in = 7'h00;
    out_ready = 1'b1;
    #3;
    chk_zero("por");
    step(2);
    chk_zero("por_held");
    resetn = 1'b1;
    exp_q.push_back(8);
    step(4);
    chk("t1_no_early", {31'd0, out_valid}, 0);
    step(1);
    chk("t1_valid", {31'd0, out_valid}, 1);
    hold(7'h7F, 3);
    chk_state("t1");

    do_reset();
    seg_in = 7'h24;
    exp_q.push_back(2);
    step(4);
    chk("t2_no_early", {31'd0, out_valid}, 0);
    step(1);
    chk("t2_valid", {31'd0, out_valid}, 1);
    chk("t2_digit", {28'd0, out_digit}, 2);
    step(1);
    chk("t2_hist", {16'd0, history}, 16'h0002);
    chk("t2_dcnt", {24'd0, digit_count}, 1);
    step(6);
    chk("t2_no_reemit", {24'd0, digit_count}, 1);
    hold(7'h7F, 2);

    hold(7'h19, 2);
    exp_q.push_back(5);
    hold(7'h12, 6);
    hold(7'h7F, 2);
    chk_state("t3");

    exp_err++;
    err_total_exp++;
    hold(7'h7E, 6);
    chk("t4_no_valid", {31'd0, out_valid}, 0);
    hold(7'h7F, 2);
    chk_state("t4");

    out_ready = 1'b0;
    seg_in = 7'h79;
    exp_q.push_back(1);
    exp_q.push_back(0);
    step(5);
    chk("t5_valid", {31'd0, out_valid}, 1);
    seg_in = 7'h40;
    step(3);
    chk("t5_frozen_valid", {31'd0, out_valid}, 1);
    chk("t5_frozen_digit", {28'd0, out_digit}, 1);
    out_ready = 1'b1;
    step(4);
    chk("t5_gap", {31'd0, out_valid}, 0);
    step(1);
    chk("t5_valid0", {31'd0, out_valid}, 1);
    chk("t5_digit0", {28'd0, out_digit}, 0);
    hold(7'h7F, 3);
    chk_state("t5");

    out_ready = 1'b0;
    hold(7'h46, 5);
    chk("rst_pending_valid", {31'd0, out_valid}, 1);
    exp_q.push_back(12);
    do_reset();
    out_ready = 1'b1;

    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(i);
      hold(glyph[i], 6);
      hold(7'h7F, 2);
    end
    chk("t6_hist", {16'd0, history}, 16'hCDEF);
    chk("t6_dcnt", {24'd0, digit_count}, 16);
    chk_state("t6");

    prev = 7'h7F;
    for (int r = 0; r < 120; r++) begin
      do begin
        d = $urandom_range(0, 9);
        p = d < 6 ? glyph[$urandom_range(0, 15)] : d < 8 ? 7'($urandom_range(0, 127)) : 7'h7F;
      end while (p == prev);
      len = $urandom_range(0, 1) ? $urandom_range(1, S - 1) : $urandom_range(S + 2, S + 5);
      if (len >= S && p != 7'h7F) begin
        d = decode(p);
        if (d >= 0) exp_q.push_back(d);
        else begin
          exp_err++;
          err_total_exp++;
        end
      end
      hold(p, len);
      prev = p;
    end
    hold(7'h7F, 4);
    chk_state("rand");
    chk("rand_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
